// File: rtl/booth_mul_scheduler_pkg.sv
// rtl/booth_mul_scheduler_pkg.sv - shared types and constants for the Booth multiplier scheduler
package booth_mul_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MC_CYCLES = 4;

    // Settle counter width; a single-cycle path still needs a one-bit counter.
    function automatic int cnt_w(input int mc);
        return (mc > 1) ? $clog2(mc) : 1;
    endfunction

endpackage

// File: rtl/booth_mul_scheduler_rr_priority_picker.sv
// rtl/booth_mul_scheduler_rr_priority_picker.sv - round-robin first-set-bit search starting at ptr
module booth_mul_scheduler_rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Walk from ptr upward, wrapping, and keep only the first asserted request.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] idx;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        pos          = 0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
            if (!grant_valid && req[idx]) begin
                grant_valid       = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// rtl/booth_mul_scheduler.sv - round-robin sharing of one external multicycle Booth multiplier
module booth_mul_scheduler
    import booth_mul_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MC_CYCLES = DEF_MC_CYCLES
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       Req_Sig,
    input  logic [NUM_REQ*WIDTH-1:0] Req_A,
    input  logic [NUM_REQ*WIDTH-1:0] Req_B,
    output logic [NUM_REQ-1:0]       Grant_Sig,
    output logic [NUM_REQ-1:0]       Done_Sig,
    output logic [2*WIDTH-1:0]       Result,
    output logic                     Busy,
    output logic [WIDTH-1:0]         Mul_A,
    output logic [WIDTH-1:0]         Mul_B,
    input  logic [2*WIDTH-1:0]       Mul_Result
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = cnt_w(MC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_CYCLES - 1);

    state_e               state_q,  state_d;
    logic [IDX_W-1:0]     ptr_q,    ptr_d;
    logic [IDX_W-1:0]     gidx_q,   gidx_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;
    logic [NUM_REQ-1:0]   done_q,   done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     mul_a_q,  mul_a_d;
    logic [WIDTH-1:0]     mul_b_q,  mul_b_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    booth_mul_scheduler_rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req          (Req_Sig),
        .ptr          (ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .grant_valid  (pick_valid)
    );

    // Operand mux driven by the one-hot pick so bases stay constant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_a = Req_A[i*WIDTH +: WIDTH];
                sel_b = Req_B[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: grant in IDLE, count settle cycles in WAIT, retire in DONE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = done_q;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    grant_d = pick_onehot;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = Mul_Result;
                    done_d   = grant_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = '0;
                grant_d = '0;
                ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight without a done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    assign Grant_Sig = grant_q;
    assign Done_Sig  = done_q;
    assign Result    = result_q;
    assign Mul_A     = mul_a_q;
    assign Mul_B     = mul_b_q;
    assign Busy      = (state_q == ST_WAIT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_booth_mul_scheduler.sv
// tb/tb_booth_mul_scheduler.sv - scoreboard bench for the Booth multiplier scheduler
module tb_booth_mul_scheduler;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int MC = 4;

    typedef struct packed {
        logic [NR-1:0]  mask;
        logic [2*W-1:0] prod;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NR-1:0]  Req_Sig;
    logic [NR*W-1:0] Req_A, Req_B;
    logic [NR-1:0]  Grant_Sig, Done_Sig;
    logic [2*W-1:0] Result, Mul_Result;
    logic           Busy;
    logic [W-1:0]   Mul_A, Mul_B;

    logic [NR-1:0]  req1;
    logic [NR*W-1:0] a1, b1;
    logic [NR-1:0]  grant1, done1;
    logic [2*W-1:0] result1, mulres1;
    logic           busy1;
    logic [W-1:0]   mula1, mulb1;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   done_count = 0;
    int   done_times[$];
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Signed 8x8 multiplier models standing in for the external Booth instances.
    assign Mul_Result = $signed({{W{Mul_A[W-1]}}, Mul_A}) * $signed({{W{Mul_B[W-1]}}, Mul_B});
    assign mulres1    = $signed({{W{mula1[W-1]}}, mula1}) * $signed({{W{mulb1[W-1]}}, mulb1});

    booth_mul_scheduler #(.NUM_REQ(NR), .WIDTH(W), .MC_CYCLES(MC)) u_dut (
        .CLK(CLK), .RST(RST), .Req_Sig(Req_Sig), .Req_A(Req_A), .Req_B(Req_B),
        .Grant_Sig(Grant_Sig), .Done_Sig(Done_Sig), .Result(Result), .Busy(Busy),
        .Mul_A(Mul_A), .Mul_B(Mul_B), .Mul_Result(Mul_Result)
    );

    booth_mul_scheduler #(.NUM_REQ(NR), .WIDTH(W), .MC_CYCLES(1)) u_dut_mc1 (
        .CLK(CLK), .RST(RST), .Req_Sig(req1), .Req_A(a1), .Req_B(b1),
        .Grant_Sig(grant1), .Done_Sig(done1), .Result(result1), .Busy(busy1),
        .Mul_A(mula1), .Mul_B(mulb1), .Mul_Result(mulres1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [2*W-1:0] prod);
        exp_t e;
        e.mask = NR'(1 << idx);
        e.prod = prod;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge CLK) begin
        exp_t e;
        if (Done_Sig != '0) begin
            done_count++;
            done_times.push_back(cyc);
            check("done_one_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(Done_Sig), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_mask", 32'(Done_Sig), 32'(e.mask));
                check("grant_at_done", 32'(Grant_Sig), 32'(e.mask));
                check("result", 32'(Result), 32'(e.prod));
            end
        end
        prev_done = (Done_Sig != '0);
    end

    task automatic run_single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] prod);
        Req_A[idx*W +: W] = a;
        Req_B[idx*W +: W] = b;
        Req_Sig[idx]      = 1'b1;
        push_exp(idx, prod);
        for (int k = 0; k <= MC + 1; k++) begin
            tick();
            check("busy", 32'(Busy), 32'(k <= MC));
            check("done_latency", 32'(Done_Sig != '0), 32'(k == MC));
            if (k == 0) begin
                check("single_grant", 32'(Grant_Sig), 32'(NR'(1 << idx)));
                check("single_mul_a", 32'(Mul_A), 32'(a));
                check("single_mul_b", 32'(Mul_B), 32'(b));
            end
            if (k == MC) Req_Sig[idx] = 1'b0;
        end
        tick();
        check("idle_result_hold", 32'(Result), 32'(prod));
        check("idle_mul_a_hold", 32'(Mul_A), 32'(a));
    endtask

    task automatic serve(input string tag, input int budget);
        int n = 0;
        while (Req_Sig != '0 && n < budget) begin
            tick();
            Req_Sig = Req_Sig & ~Done_Sig;
            n++;
        end
        check({tag, "_served"}, 32'(Req_Sig), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  32'(Grant_Sig), 32'd0);
        check({tag, "_done"},   32'(Done_Sig),  32'd0);
        check({tag, "_result"}, 32'(Result),    32'd0);
        check({tag, "_busy"},   32'(Busy),      32'd0);
        check({tag, "_mul_a"},  32'(Mul_A),     32'd0);
        check({tag, "_mul_b"},  32'(Mul_B),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n;
        RST = 1'b1; Req_Sig = '0; Req_A = '0; Req_B = '0;
        req1 = '0; a1 = '0; b1 = '0;
        tick(); tick();
        check_all_zero("reset");
        check("reset_mc1_busy", 32'(busy1), 32'd0);
        check("reset_mc1_result", 32'(result1), 32'd0);
        RST = 1'b0;
        tick();

        run_single(0, 8'd7, 8'd9, 16'd63);
        run_single(1, 8'hFD, 8'd5, 16'hFFF1);

        // Contention from reset: all four held, grants must rotate 0,1,2,3,0.
        RST = 1'b1; tick(); RST = 1'b0;
        Req_A = {8'h80, 8'd100, 8'hFE, 8'd3};
        Req_B = {8'h80, 8'hFF,  8'd7,  8'd5};
        push_exp(0, 16'd15);
        push_exp(1, 16'hFFF2);
        push_exp(2, 16'hFF9C);
        push_exp(3, 16'h4000);
        push_exp(0, 16'd15);
        base = done_count;
        n = done_times.size();
        Req_Sig = 4'b1111;
        for (int t = 0; t < 60 && done_count < base + 5; t++) tick();
        check("contention_count", 32'(done_count - base), 32'd5);
        Req_Sig = '0;
        tick(); tick();
        for (int i = 1; i < 5; i++) begin
            if (n + i < done_times.size())
                check("contention_spacing", 32'(done_times[n+i] - done_times[n+i-1]), 32'(MC + 2));
        end
        check("contention_sb_empty", 32'(exp_q.size()), 32'd0);

        // Rotation: after serving 2, requester 0 outranks a still-requesting 2.
        run_single(2, 8'd11, 8'd13, 16'd143);
        Req_A[0*W +: W] = 8'd6;  Req_B[0*W +: W] = 8'hFE;
        Req_A[2*W +: W] = 8'd10; Req_B[2*W +: W] = 8'd10;
        push_exp(0, 16'hFFF4);
        push_exp(2, 16'd100);
        Req_Sig = 4'b0101;
        tick();
        check("rotation_grant", 32'(Grant_Sig), 32'b0001);
        serve("rotation", 40);
        check("rotation_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while cnt==2: operation abandoned, pointer back to 0.
        Req_A[3*W +: W] = 8'd9; Req_B[3*W +: W] = 8'd9;
        Req_Sig = 4'b1000;
        tick();
        check("midreset_grant", 32'(Grant_Sig), 32'b1000);
        tick(); tick();
        RST = 1'b1; Req_Sig = '0;
        tick();
        check_all_zero("midreset");
        RST = 1'b0;
        for (int t = 0; t < MC + 3; t++) tick();
        check("midreset_no_done", 32'(done_count), 32'(base + 5 + 3));
        Req_A[1*W +: W] = 8'd3; Req_B[1*W +: W] = 8'd4;
        push_exp(1, 16'd12);
        push_exp(3, 16'd81);
        Req_Sig = 4'b1010;
        tick();
        check("ptr_after_reset", 32'(Grant_Sig), 32'b0010);
        serve("after_reset", 40);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        // Single-cycle build: done one clock after grant, operands held through DONE.
        a1[0 +: W] = 8'hFF; b1[0 +: W] = 8'hFF;
        req1 = 4'b0001;
        tick();
        check("mc1_grant", 32'(grant1), 32'b0001);
        check("mc1_no_early_done", 32'(done1), 32'd0);
        check("mc1_mul_a", 32'(mula1), 32'hFF);
        tick();
        check("mc1_done", 32'(done1), 32'b0001);
        check("mc1_result", 32'(result1), 32'h0001);
        check("mc1_mul_a_done", 32'(mula1), 32'hFF);
        check("mc1_mul_b_done", 32'(mulb1), 32'hFF);
        req1 = '0;
        tick();
        check("mc1_done_clear", 32'(done1), 32'd0);
        check("mc1_grant_clear", 32'(grant1), 32'd0);
        check("mc1_busy_clear", 32'(busy1), 32'd0);
        check("mc1_mul_a_hold", 32'(mula1), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
